// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one unified memory port between the core
// (port C) and a debug/program-loader master (port D).
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | normal arbitration: C has priority, D wins once starved
// DRAIN  | lock requested; no grants until all in-flight reads return
// LOCKED | D owns the port exclusively, core is held off
//
// Grants are combinational in the request cycle. Read ownership travels
// through a READ_LATENCY-deep tag shift register so that returning data is
// steered to the port that issued the read.

module mem_port_arbiter #(
   parameter int READ_LATENCY = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        c_req,
   input  logic        c_we,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [2:0]  c_funct3,
   output logic        c_gnt,
   output logic        c_stall,
   output logic        c_rvalid,
   output logic [31:0] c_rdata,

   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_funct3,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,

   input  logic        d_lock,
   output logic        d_lock_ack,

   output logic        mem_wren,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_funct3,
   input  logic [31:0] mem_rdata
);

   // STARVE_LIMIT is at most 255, so an 8-bit counter always suffices
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t                  state_q;
   logic                    lock_ack_q;
   logic [CNT_W-1:0]        starve_q;
   logic [READ_LATENCY-1:0] tag_vld_q;
   logic [READ_LATENCY-1:0] tag_port_q;

   logic                    starve_hit;
   logic                    c_win;
   logic                    d_win;
   logic                    rd_push;
   logic                    rd_port;
   logic                    pipe_busy;

   assign starve_hit = (starve_q == STARVE_MAX);

   // Arbitration decision for the current cycle, based on the FSM state
   always_comb begin
      c_win = 1'b0;
      d_win = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (c_req && !(d_req && starve_hit)) begin
               c_win = 1'b1;
            end else if (d_req) begin
               d_win = 1'b1;
            end
         end
         ST_LOCKED: begin
            d_win = d_req;
         end
         default: begin
            c_win = 1'b0;
            d_win = 1'b0;
         end
      endcase
   end

   // Grants are forced low while reset is asserted, independent of state
   assign c_gnt   = c_win & reset;
   assign d_gnt   = d_win & reset;
   assign c_stall = c_req & ~c_gnt;

   // Memory-side mux: port D only when it holds the grant, otherwise port C
   always_comb begin
      mem_addr   = c_addr;
      mem_wdata  = c_wdata;
      mem_funct3 = c_funct3;
      if (d_gnt) begin
         mem_addr   = d_addr;
         mem_wdata  = d_wdata;
         mem_funct3 = d_funct3;
      end
   end

   assign mem_wren = (c_gnt & c_we) | (d_gnt & d_we);

   // A granted read pushes a tag; the tag records which port owns the data
   assign rd_push = (c_gnt & ~c_we) | (d_gnt & ~d_we);
   assign rd_port = d_gnt;

   // Reads still outstanding after this cycle; the last stage retires now
   always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < READ_LATENCY - 1; i++) begin
         pipe_busy = pipe_busy | tag_vld_q[i];
      end
   end

   // Read tag shift register; reset discards anything in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_vld_q  <= '0;
         tag_port_q <= '0;
      end else begin
         tag_vld_q[0]  <= rd_push;
         tag_port_q[0] <= rd_port;
         for (int i = 1; i < READ_LATENCY; i++) begin
            tag_vld_q[i]  <= tag_vld_q[i-1];
            tag_port_q[i] <= tag_port_q[i-1];
         end
      end
   end

   assign c_rvalid = tag_vld_q[READ_LATENCY-1] & ~tag_port_q[READ_LATENCY-1];
   assign d_rvalid = tag_vld_q[READ_LATENCY-1] &  tag_port_q[READ_LATENCY-1];
   assign c_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

   // Starvation counter: counts consecutive cycles D waits, saturating
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_q <= '0;
      end else if (d_gnt || !d_req) begin
         starve_q <= '0;
      end else if (!starve_hit) begin
         starve_q <= starve_q + 8'd1;
      end
   end

   // Lock sequencing FSM with registered lock acknowledge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         lock_ack_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               lock_ack_q <= 1'b0;
               if (d_lock) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!d_lock) begin
                  state_q    <= ST_RUN;
                  lock_ack_q <= 1'b0;
               end else if (!pipe_busy) begin
                  state_q    <= ST_LOCKED;
                  lock_ack_q <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (!d_lock) begin
                  state_q    <= ST_RUN;
                  lock_ack_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_RUN;
               lock_ack_q <= 1'b0;
            end
         endcase
      end
   end

   assign d_lock_ack = lock_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances (READ_LATENCY 1, 2, 3)
// share the same requester stimulus; each has its own memory model that
// returns a fixed pattern for the address presented READ_LATENCY cycles ago.

module tb_mem_port_arbiter;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_req, c_we, d_req, d_we, d_lock;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic [2:0]  c_funct3, d_funct3;

   logic        c_gnt_a    [NI];
   logic        c_stall_a  [NI];
   logic        c_rvalid_a [NI];
   logic [31:0] c_rdata_a  [NI];
   logic        d_gnt_a    [NI];
   logic        d_rvalid_a [NI];
   logic [31:0] d_rdata_a  [NI];
   logic        d_lock_ack_a [NI];
   logic        mem_wren_a [NI];
   logic [31:0] mem_addr_a [NI];
   logic [31:0] mem_wdata_a [NI];
   logic [2:0]  mem_funct3_a [NI];
   logic [31:0] mem_rdata_a [NI];

   int n_checks = 0;
   int n_errs   = 0;

   always #5 clk = ~clk;

   // Memory contents: 0x40 holds 0x12345678, elsewhere {addr[15:0], ~addr[15:0]}
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h40) return 32'h1234_5678;
      return {a[15:0], ~a[15:0]};
   endfunction

   genvar g;
   for (g = 0; g < NI; g++) begin : g_dut
      logic [31:0] addr_dly [g+1];

      mem_port_arbiter #(.READ_LATENCY(g + 1), .STARVE_LIMIT(8)) u_dut (
         .clk        (clk),
         .reset      (reset),
         .c_req      (c_req),
         .c_we       (c_we),
         .c_addr     (c_addr),
         .c_wdata    (c_wdata),
         .c_funct3   (c_funct3),
         .c_gnt      (c_gnt_a[g]),
         .c_stall    (c_stall_a[g]),
         .c_rvalid   (c_rvalid_a[g]),
         .c_rdata    (c_rdata_a[g]),
         .d_req      (d_req),
         .d_we       (d_we),
         .d_addr     (d_addr),
         .d_wdata    (d_wdata),
         .d_funct3   (d_funct3),
         .d_gnt      (d_gnt_a[g]),
         .d_rvalid   (d_rvalid_a[g]),
         .d_rdata    (d_rdata_a[g]),
         .d_lock     (d_lock),
         .d_lock_ack (d_lock_ack_a[g]),
         .mem_wren   (mem_wren_a[g]),
         .mem_addr   (mem_addr_a[g]),
         .mem_wdata  (mem_wdata_a[g]),
         .mem_funct3 (mem_funct3_a[g]),
         .mem_rdata  (mem_rdata_a[g])
      );

      // Memory read pipeline: data appears READ_LATENCY cycles after the address
      always @(posedge clk) begin
         addr_dly[0] <= mem_addr_a[g];
         for (int i = 1; i < g + 1; i++) addr_dly[i] <= addr_dly[i-1];
      end

      assign mem_rdata_a[g] = mem_word(addr_dly[g]);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      c_req = 1'b0; c_we = 1'b0; d_req = 1'b0; d_we = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; d_lock = 1'b0;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_funct3 = 3'b010;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_funct3 = 3'b010;

      // Reset state: grants gated even with a live request
      sample();
      check_val("rst_c_gnt",  32'(c_gnt_a[0]), 0);
      check_val("rst_ack",    32'(d_lock_ack_a[0]), 0);
      check_val("rst_c_rv",   32'(c_rvalid_a[0]), 0);
      check_val("rst_d_rv",   32'(d_rvalid_a[0]), 0);
      check_val("rst_wren",   32'(mem_wren_a[0]), 0);
      tick();
      reset = 1'b1; c_req = 1'b0;
      tick();

      // Core read, READ_LATENCY=1
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
      sample();
      check_val("rd1_c_gnt", 32'(c_gnt_a[0]), 1);
      check_val("rd1_d_gnt", 32'(d_gnt_a[0]), 0);
      check_val("rd1_addr",  mem_addr_a[0], 32'h40);
      tick();
      c_req = 1'b0;
      sample();
      check_val("rd1_c_rv",   32'(c_rvalid_a[0]), 1);
      check_val("rd1_c_data", c_rdata_a[0], 32'h1234_5678);
      check_val("rd1_d_rv",   32'(d_rvalid_a[0]), 0);
      tick();
      sample();
      check_val("rd1_c_rv_once", 32'(c_rvalid_a[0]), 0);
      tick();

      // Continuous contention: C wins 8, D wins the 9th, repeating
      c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0;
      c_addr = 32'h500; d_addr = 32'h600;
      for (int k = 0; k < 18; k++) begin
         logic dwin;
         dwin = (k == 8) || (k == 17);
         sample();
         check_val($sformatf("cont_c_gnt_%0d", k), 32'(c_gnt_a[0]), 32'(!dwin));
         check_val($sformatf("cont_d_gnt_%0d", k), 32'(d_gnt_a[0]), 32'(dwin));
         check_val($sformatf("cont_stall_%0d", k), 32'(c_stall_a[0]), 32'(dwin));
         tick();
      end

      // Counter clears when D drops its request
      for (int k = 0; k < 4; k++) begin
         sample();
         check_val($sformatf("clr_pre_%0d", k), 32'(d_gnt_a[0]), 0);
         tick();
      end
      d_req = 1'b0;
      tick();
      d_req = 1'b1;
      for (int k = 0; k < 9; k++) begin
         sample();
         check_val($sformatf("clr_post_%0d", k), 32'(d_gnt_a[0]), 32'(k == 8));
         tick();
      end
      idle(4);

      // Write routing from port D
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
      sample();
      check_val("wr_d_gnt",   32'(d_gnt_a[0]), 1);
      check_val("wr_c_gnt",   32'(c_gnt_a[0]), 0);
      check_val("wr_wren",    32'(mem_wren_a[0]), 1);
      check_val("wr_addr",    mem_addr_a[0], 32'h100);
      check_val("wr_wdata",   mem_wdata_a[0], 32'hDEAD_BEEF);
      check_val("wr_funct3",  32'(mem_funct3_a[0]), 32'd2);
      tick();
      d_req = 1'b0; d_we = 1'b0;
      sample();
      check_val("wr_no_d_rv", 32'(d_rvalid_a[0]), 0);
      check_val("wr_no_c_rv", 32'(c_rvalid_a[0]), 0);
      check_val("wr_idle_wren", 32'(mem_wren_a[0]), 0);
      check_val("wr_idle_addr", mem_addr_a[0], 32'h500);
      idle(5);

      // Lock with an in-flight read, READ_LATENCY=3
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h200;
      sample();
      check_val("lk_c_gnt0", 32'(c_gnt_a[2]), 1);
      tick();
      c_req = 1'b0; d_lock = 1'b1;
      sample();
      check_val("lk_ack1", 32'(d_lock_ack_a[2]), 0);
      tick();
      c_req = 1'b1; c_addr = 32'h204;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h800; d_wdata = 32'h0000_00AA;
      sample();
      check_val("lk_drain_c_gnt", 32'(c_gnt_a[2]), 0);
      check_val("lk_drain_d_gnt", 32'(d_gnt_a[2]), 0);
      check_val("lk_drain_stall", 32'(c_stall_a[2]), 1);
      check_val("lk_drain_c_rv",  32'(c_rvalid_a[2]), 0);
      check_val("lk_drain_ack",   32'(d_lock_ack_a[2]), 0);
      tick();
      sample();
      check_val("lk_ret_c_rv",   32'(c_rvalid_a[2]), 1);
      check_val("lk_ret_data",   c_rdata_a[2], 32'h0200_FDFF);
      check_val("lk_ret_d_gnt",  32'(d_gnt_a[2]), 0);
      check_val("lk_ret_ack",    32'(d_lock_ack_a[2]), 0);
      tick();
      sample();
      check_val("lk_ack",        32'(d_lock_ack_a[2]), 1);
      check_val("lk_c_gnt",      32'(c_gnt_a[2]), 0);
      check_val("lk_c_stall",    32'(c_stall_a[2]), 1);
      check_val("lk_d_gnt",      32'(d_gnt_a[2]), 1);
      check_val("lk_wren",       32'(mem_wren_a[2]), 1);
      check_val("lk_waddr",      mem_addr_a[2], 32'h800);
      tick();
      d_lock = 1'b0;
      sample();
      check_val("lk_rel_ack",    32'(d_lock_ack_a[2]), 1);
      check_val("lk_rel_d_gnt",  32'(d_gnt_a[2]), 1);
      tick();
      d_req = 1'b0; d_we = 1'b0;
      sample();
      check_val("lk_run_ack",    32'(d_lock_ack_a[2]), 0);
      check_val("lk_run_c_gnt",  32'(c_gnt_a[2]), 1);
      tick();
      idle(5);

      // Reset in the middle of a read, READ_LATENCY=3
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h240;
      sample();
      check_val("rr_c_gnt0", 32'(c_gnt_a[2]), 1);
      tick();
      reset = 1'b0;
      sample();
      check_val("rr_c_gnt",  32'(c_gnt_a[2]), 0);
      check_val("rr_d_gnt",  32'(d_gnt_a[2]), 0);
      check_val("rr_ack",    32'(d_lock_ack_a[2]), 0);
      check_val("rr_c_rv",   32'(c_rvalid_a[2]), 0);
      check_val("rr_d_rv",   32'(d_rvalid_a[2]), 0);
      check_val("rr_wren",   32'(mem_wren_a[2]), 0);
      tick();
      reset = 1'b1; c_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample();
         check_val($sformatf("rr_post_c_rv_%0d", k), 32'(c_rvalid_a[2]), 0);
         check_val($sformatf("rr_post_d_rv_%0d", k), 32'(d_rvalid_a[2]), 0);
         tick();
      end
      c_req = 1'b1;
      sample();
      check_val("rr_run_c_gnt", 32'(c_gnt_a[2]), 1);
      tick();
      idle(5);

      // Interleaved C, D, C reads, READ_LATENCY=2
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h300;
      sample();
      check_val("il_g0_c", 32'(c_gnt_a[1]), 1);
      tick();
      c_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      sample();
      check_val("il_g1_d", 32'(d_gnt_a[1]), 1);
      tick();
      d_req = 1'b0; c_req = 1'b1; c_addr = 32'h304;
      sample();
      check_val("il_g2_c",   32'(c_gnt_a[1]), 1);
      check_val("il_r0_crv", 32'(c_rvalid_a[1]), 1);
      check_val("il_r0_drv", 32'(d_rvalid_a[1]), 0);
      check_val("il_r0_dat", c_rdata_a[1], 32'h0300_FCFF);
      tick();
      c_req = 1'b0;
      sample();
      check_val("il_r1_crv", 32'(c_rvalid_a[1]), 0);
      check_val("il_r1_drv", 32'(d_rvalid_a[1]), 1);
      check_val("il_r1_dat", d_rdata_a[1], 32'h0400_FBFF);
      tick();
      sample();
      check_val("il_r2_crv", 32'(c_rvalid_a[1]), 1);
      check_val("il_r2_drv", 32'(d_rvalid_a[1]), 0);
      check_val("il_r2_dat", c_rdata_a[1], 32'h0304_FCFB);
      tick();
      sample();
      check_val("il_r3_crv", 32'(c_rvalid_a[1]), 0);
      check_val("il_r3_drv", 32'(d_rvalid_a[1]), 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
